// File: rtl/ramtest_master.sv
// Power-on PSRAM self-test: a Wishbone master that writes a seeded pattern over an
// address window, reads it back, and reports pass, first mismatch, or bus timeout.
module ramtest_master #(
    parameter logic [22:0] START_ADR = 23'h000000,
    parameter logic [22:0] END_ADR   = 23'h0000FF,
    parameter logic [15:0] SEED      = 16'hA5C3,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk2x_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        ram_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [22:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [22:0] fail_adr_o,
    output logic [15:0] fail_exp_o,
    output logic [15:0] fail_got_o
);

    localparam int unsigned ADR_W = 23;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_PASS, S_FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [ADR_W-1:0]   adr, adr_nxt;
    logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_nxt;

    logic               cyc_nxt, stb_nxt, we_nxt;
    logic [1:0]         sel_nxt;
    logic [ADR_W-1:0]   wb_adr_nxt, fail_adr_nxt;
    logic [DAT_W-1:0]   wb_dat_nxt, fail_exp_nxt, fail_got_nxt;
    logic               busy_nxt, done_nxt, fail_nxt, timeout_nxt;

    function automatic logic [DAT_W-1:0] pat(input logic [DAT_W-1:0] a);
        return a ^ SEED;
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_nxt    = state;
        adr_nxt      = adr;
        tmo_cnt_nxt  = tmo_cnt;
        cyc_nxt      = wb_cyc_o;
        stb_nxt      = wb_stb_o;
        we_nxt       = wb_we_o;
        sel_nxt      = wb_sel_o;
        wb_adr_nxt   = wb_adr_o;
        wb_dat_nxt   = wb_dat_o;
        busy_nxt     = busy_o;
        done_nxt     = done_o;
        fail_nxt     = fail_o;
        timeout_nxt  = timeout_o;
        fail_adr_nxt = fail_adr_o;
        fail_exp_nxt = fail_exp_o;
        fail_got_nxt = fail_got_o;

        case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start_i) begin
                    state_nxt    = S_WAIT_RDY;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    fail_nxt     = 1'b0;
                    timeout_nxt  = 1'b0;
                    fail_adr_nxt = '0;
                    fail_exp_nxt = '0;
                    fail_got_nxt = '0;
                end
            end
            S_WAIT_RDY: begin
                if (ram_ready_i) begin
                    state_nxt   = S_WR_REQ;
                    adr_nxt     = START_ADR;
                    tmo_cnt_nxt = '0;
                    {cyc_nxt, stb_nxt, we_nxt} = 3'b111;
                    sel_nxt     = 2'b11;
                    wb_adr_nxt  = START_ADR;
                    wb_dat_nxt  = pat(START_ADR[DAT_W-1:0]);
                end
            end
            S_WR_REQ, S_RD_REQ: begin
                if (wb_ack_i) begin
                    {cyc_nxt, stb_nxt, we_nxt} = 3'b000;
                    sel_nxt = 2'b00;
                    if (state == S_WR_REQ) begin
                        state_nxt = S_WR_GAP;
                    end else if (wb_dat_i != pat(adr[DAT_W-1:0])) begin
                        state_nxt    = S_FAIL;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        fail_nxt     = 1'b1;
                        fail_adr_nxt = adr;
                        fail_exp_nxt = pat(adr[DAT_W-1:0]);
                        fail_got_nxt = wb_dat_i;
                    end else begin
                        state_nxt = S_RD_GAP;
                    end
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Slave hung: abandon the access and report where it stalled
                    {cyc_nxt, stb_nxt, we_nxt} = 3'b000;
                    sel_nxt      = 2'b00;
                    state_nxt    = S_FAIL;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    fail_nxt     = 1'b1;
                    timeout_nxt  = 1'b1;
                    fail_adr_nxt = adr;
                    fail_exp_nxt = pat(adr[DAT_W-1:0]);
                    fail_got_nxt = '0;
                end else begin
                    tmo_cnt_nxt = CNT_W'(tmo_cnt + 1'b1);
                end
            end
            S_WR_GAP: begin
                tmo_cnt_nxt = '0;
                {cyc_nxt, stb_nxt} = 2'b11;
                sel_nxt = 2'b11;
                if (adr == END_ADR) begin
                    state_nxt  = S_RD_REQ;
                    adr_nxt    = START_ADR;
                    we_nxt     = 1'b0;
                    wb_adr_nxt = START_ADR;
                end else begin
                    state_nxt  = S_WR_REQ;
                    adr_nxt    = ADR_W'(adr + 1'b1);
                    we_nxt     = 1'b1;
                    wb_adr_nxt = ADR_W'(adr + 1'b1);
                    wb_dat_nxt = pat(DAT_W'(adr + 1'b1));
                end
            end
            S_RD_GAP: begin
                if (adr == END_ADR) begin
                    state_nxt = S_PASS;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    fail_nxt  = 1'b0;
                end else begin
                    state_nxt   = S_RD_REQ;
                    adr_nxt     = ADR_W'(adr + 1'b1);
                    tmo_cnt_nxt = '0;
                    {cyc_nxt, stb_nxt, we_nxt} = 3'b110;
                    sel_nxt     = 2'b11;
                    wb_adr_nxt  = ADR_W'(adr + 1'b1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk2x_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            adr        <= '0;
            tmo_cnt    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            fail_adr_o <= '0;
            fail_exp_o <= '0;
            fail_got_o <= '0;
        end else begin
            state      <= state_nxt;
            adr        <= adr_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            wb_cyc_o   <= cyc_nxt;
            wb_stb_o   <= stb_nxt;
            wb_we_o    <= we_nxt;
            wb_sel_o   <= sel_nxt;
            wb_adr_o   <= wb_adr_nxt;
            wb_dat_o   <= wb_dat_nxt;
            busy_o     <= busy_nxt;
            done_o     <= done_nxt;
            fail_o     <= fail_nxt;
            timeout_o  <= timeout_nxt;
            fail_adr_o <= fail_adr_nxt;
            fail_exp_o <= fail_exp_nxt;
            fail_got_o <= fail_got_nxt;
        end
    end

endmodule

// File: tb/tb_ramtest_master.sv
// Bench for ramtest_master: a behavioural PSRAM responder with configurable ACK
// latency, read corruption and hang, checked against expected run outcomes.
module tb_ramtest_master;

    localparam int T_START = 0;
    localparam int T_END   = 3;
    localparam int NW      = T_END - T_START + 1;
    localparam int TMO     = 64;
    localparam logic [15:0] T_SEED = 16'hA5C3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0, start_i = 1'b0, ram_ready_i = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [22:0] wb_adr_o, fail_adr_o;
    logic [15:0] wb_dat_o, fail_exp_o, fail_got_o;
    logic [15:0] rd_r = 16'h0;
    logic        ack_r = 1'b0;
    logic        busy_o, done_o, fail_o, timeout_o;

    always #5 clk = ~clk;

    ramtest_master #(
        .START_ADR(23'(T_START)), .END_ADR(23'(T_END)), .SEED(T_SEED), .TIMEOUT(TMO)
    ) dut (
        .clk2x_i(clk), .reset_i(reset_i), .start_i(start_i), .ram_ready_i(ram_ready_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(rd_r), .wb_ack_i(ack_r),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .fail_adr_o(fail_adr_o), .fail_exp_o(fail_exp_o), .fail_got_o(fail_got_o)
    );

    // Responder: ACK on the cfg_ack_clk-th clock of STB, optional corruption/hang
    int          cfg_ack_clk = 6, cfg_corrupt = -1, cfg_hang = -1;
    int          rcnt = 0, acc_idx = 0;
    logic        rsp_clr = 1'b0;
    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (reset_i || rsp_clr) begin
            ack_r <= 1'b0; rcnt <= 0; acc_idx <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (ack_r) begin
            ack_r <= 1'b0; rcnt <= 0; acc_idx <= acc_idx + 1;
            if (wb_we_o) mem[wb_adr_o[7:0]] <= wb_dat_o;
        end else if (wb_cyc_o && wb_stb_o && acc_idx != cfg_hang) begin
            rcnt <= rcnt + 1;
            if (rcnt + 1 == cfg_ack_clk - 1) begin
                ack_r <= 1'b1;
                rd_r  <= (!wb_we_o && int'(wb_adr_o) == cfg_corrupt) ? 16'hD00D : mem[wb_adr_o[7:0]];
            end
        end
    end

    typedef struct {
        int ack_clk; int corrupt; int hang; bit rst; int gate;
        bit exp_fail; bit exp_tmo; int exp_adr; int exp_exp; int exp_got;
        int exp_cyc; int exp_acks;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    logic [39:0] log_q[$];
    logic        prev_stb = 1'b0, prev_ack = 1'b0;
    logic [39:0] prev_bus = '0;

    function automatic logic [15:0] tpat(input int a);
        return 16'(a) ^ T_SEED;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy_o,
                     done_o, fail_o, timeout_o, fail_adr_o, fail_exp_o, fail_got_o});
    endfunction

    // Bus protocol watch for the current cycle, then advance one clock
    task automatic step();
        if (wb_stb_o) begin
            chk("sel_cyc_with_stb", {wb_cyc_o, wb_sel_o}, 3'b111);
            if (prev_stb && !prev_ack)
                chk("bus_stable", {wb_we_o, wb_adr_o, wb_dat_o}, prev_bus);
            if (ack_r) log_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
        end
        prev_stb = wb_stb_o; prev_ack = ack_r; prev_bus = {wb_we_o, wb_adr_o, wb_dat_o};
        @(posedge clk); #1;
    endtask

    task automatic run(input vec_t v, input string nm);
        int n;
        cfg_ack_clk = v.ack_clk; cfg_corrupt = v.corrupt; cfg_hang = v.hang;
        start_i = 1'b0; ram_ready_i = 1'b0;
        if (v.rst) begin
            reset_i = 1'b1; step(); step(); reset_i = 1'b0;
            chk({nm, "/reset_outs"}, all_outs(), '0);
        end else begin
            rsp_clr = 1'b1; step(); rsp_clr = 1'b0;
        end
        log_q.delete(); prev_stb = 1'b0; prev_ack = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        chk({nm, "/start_status"},
            {busy_o, done_o, fail_o, timeout_o, fail_adr_o, fail_exp_o, fail_got_o, wb_cyc_o},
            {1'b1, 58'h0, 1'b0});
        for (int i = 0; i < v.gate; i++) begin
            step();
            chk({nm, "/boot_gate"}, {busy_o, wb_cyc_o}, 2'b10);
        end
        ram_ready_i = 1'b1; step();
        chk({nm, "/first_wr"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
            {5'b11111, 23'(T_START), tpat(T_START)});
        n = 0;
        while (!done_o && n < 2000) begin
            start_i = (n == 20);
            step();
            n++;
        end
        start_i = 1'b0;
        chk({nm, "/cycles_to_done"}, 128'(n), 128'(v.exp_cyc));
        chk({nm, "/status"}, {done_o, busy_o, wb_cyc_o, wb_stb_o, fail_o, timeout_o},
            {4'b1000, v.exp_fail, v.exp_tmo});
        chk({nm, "/fail_info"}, {fail_adr_o, fail_exp_o, fail_got_o},
            {23'(v.exp_adr), 16'(v.exp_exp), 16'(v.exp_got)});
        chk({nm, "/ack_count"}, 128'(log_q.size()), 128'(v.exp_acks));
        foreach (log_q[i]) begin
            chk({nm, "/acc_we_adr"}, log_q[i][39:16], {(i < NW), 23'(T_START + i % NW)});
            if (i < NW) chk({nm, "/acc_wdat"}, log_q[i][15:0], tpat(T_START + i % NW));
        end
    endtask

    // Outcome of a run from the access-level rules: each access costs N+1 clocks
    function automatic vec_t model(input int n, input int mode, input int k, input bit rst);
        vec_t v;
        v = '{n, -1, -1, rst, 3, 1'b0, 1'b0, 0, 0, 0, 2 * NW * (n + 1), 2 * NW};
        if (mode == 1) begin
            v.corrupt = T_START + k; v.exp_fail = 1'b1; v.exp_adr = T_START + k;
            v.exp_exp = int'(tpat(T_START + k)); v.exp_got = 16'hD00D;
            v.exp_cyc = (NW + k) * (n + 1) + n; v.exp_acks = NW + k + 1;
        end else if (mode == 2) begin
            v.hang = k; v.exp_fail = 1'b1; v.exp_tmo = 1'b1; v.exp_adr = T_START + k % NW;
            v.exp_exp = int'(tpat(T_START + k % NW)); v.exp_got = 0;
            v.exp_cyc = k * (n + 1) + TMO; v.exp_acks = k;
        end
        return v;
    endfunction

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{6, -1, -1, 1'b1, 100, 1'b0, 1'b0, 0, 0,       0,       56, 8};
        tbl[1] = '{2, -1, -1, 1'b1, 3,   1'b0, 1'b0, 0, 0,       0,       24, 8};
        tbl[2] = '{6,  2, -1, 1'b1, 3,   1'b1, 1'b0, 2, 'hA5C1, 'hD00D,   48, 7};
        tbl[3] = '{6, -1,  0, 1'b1, 3,   1'b1, 1'b1, 0, 'hA5C3,  0,       64, 0};
        tbl[4] = '{6, -1,  5, 1'b0, 3,   1'b1, 1'b1, 1, 'hA5C2,  0,       99, 5};
        tbl[5] = '{3,  3, -1, 1'b0, 3,   1'b1, 1'b0, 3, 'hA5C0, 'hD00D,   31, 8};

        @(posedge clk); #1;
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Reset during the read of address 1, then a clean restart
        cfg_ack_clk = 6; cfg_corrupt = -1; cfg_hang = -1;
        reset_i = 1'b1; step(); step(); reset_i = 1'b0;
        ram_ready_i = 1'b0; start_i = 1'b1; step(); start_i = 1'b0;
        ram_ready_i = 1'b1; step();
        n = 0;
        while (n < 37) begin step(); n++; end
        chk("midrst/in_read1", {wb_stb_o, wb_we_o, wb_adr_o}, {2'b10, 23'd1});
        reset_i = 1'b1; step(); reset_i = 1'b0;
        chk("midrst/outs_cleared", all_outs(), '0);
        run('{6, -1, -1, 1'b0, 3, 1'b0, 1'b0, 0, 0, 0, 56, 8}, "midrst_restart");

        for (int r = 0; r < 6; r++) begin
            int mode, k;
            mode = int'($urandom_range(0, 2));
            k    = (mode == 2) ? int'($urandom_range(0, 2 * NW - 1)) : int'($urandom_range(0, NW - 1));
            run(model(int'($urandom_range(2, 9)), mode, k, 1'($urandom_range(0, 1))),
                $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
